reaction_game_fsm: RTL and testbench
====================================

REACTION_GAME_FSM -- requirements
Module: reaction_game_fsm

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, input clock frequency in Hz; MS_TICKS = CLK_HZ/1000 clocks per millisecond.
REQ-002 Parameter MIN_WAIT_MS, default 1000, minimum random pre-GO delay in ms.
REQ-003 Parameter MAX_MS, default 9999, saturation and timeout value of the reaction counter in ms.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 start  input  1  synchronous level, player start/restart button, active-high.
REQ-007 react  input  1  synchronous level, player reaction button, active-high.
REQ-008 hex_instructions  output  3  display command to the HEX display controller: 000 off, 001 "PLAY", 010 "2 soon", 100 reaction time.
REQ-009 go_led  output  1  high while the player is required to react.
REQ-010 reaction_ms  output  14  last latched reaction time in ms, 0..MAX_MS.
REQ-011 busy  output  1  high in WAIT and GO.

Function
REQ-012 start and react SHALL be rising-edge detected internally; "press" below means a 0->1 edge; held levels cause no repeat.
REQ-013 States SHALL be IDLE, WAIT, GO, SOON, DONE.
REQ-014 IDLE: hex_instructions=001, go_led=0; a start press goes to WAIT.
REQ-015 On entry to WAIT, wait_ms SHALL be latched as MIN_WAIT_MS + lfsr[10:0] (range MIN_WAIT_MS..MIN_WAIT_MS+2047).
REQ-016 WAIT: hex_instructions=000, go_led=0; a react press goes to SOON; when wait_ms ms ticks have elapsed, go to GO.
REQ-017 In WAIT, a react press in the same cycle as the final ms tick SHALL go to SOON (react has priority).
REQ-018 GO: hex_instructions=000, go_led=1; ms counter starts at 0 on entry and increments per ms tick.
REQ-019 A react press in GO SHALL latch the current ms count into reaction_ms and go to DONE in the same clock edge.
REQ-020 If the GO counter reaches MAX_MS without a react press, reaction_ms SHALL be set to MAX_MS and the state goes to DONE; the counter never exceeds MAX_MS.
REQ-021 SOON: hex_instructions=010; DONE: hex_instructions=100; go_led=0 in both; a start press goes to WAIT; reaction_ms is unchanged by SOON.
REQ-022 A start press in WAIT or GO SHALL be ignored; react presses in IDLE, SOON, DONE SHALL be ignored.
REQ-023 Simultaneous start and react presses SHALL be resolved by the current state's rules: start only acts in IDLE, SOON, DONE; react only acts in WAIT, GO.
REQ-024 The ms prescaler SHALL count 0..MS_TICKS-1, pulse one cycle on wrap, and be cleared to 0 on every entry into WAIT and GO, so the first tick occurs MS_TICKS cycles after entry.
REQ-025 LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, advancing every clock including idle, never all-zero.
REQ-026 All outputs SHALL be registered or decoded directly from the state register; no combinational path from start/react to outputs.

Reset
REQ-027 rst SHALL force state=IDLE, hex_instructions=001, go_led=0, busy=0, reaction_ms=0, prescaler=0, ms counter=0, edge-detect registers=0, LFSR=16'hACE1.
REQ-028 rst asserted in any state (including mid-GO) SHALL take effect on the next edge and discard the measurement in progress.
REQ-029 A start level held high across rst deassertion SHALL NOT count as a press.

Structure
REQ-030 Package reaction_pkg SHALL hold the state enum, the four hex_instructions codes as named constants, and the LFSR seed.
REQ-031 Sub-module ms_tick_gen (parameter MS_TICKS; inputs clk, rst, clear; output tick) SHALL implement the prescaler.
REQ-032 Target size 120-400 lines of RTL including ms_tick_gen.

Verification (CLK_HZ=4000, MS_TICKS=4, MIN_WAIT_MS=5, MAX_MS=20)
REQ-033 Reset, then idle 10 cycles -> hex_instructions=001, go_led=0, reaction_ms=0.
REQ-034 Start press, no react -> go_led rises exactly 4*wait_ms cycles after WAIT entry, wait_ms = 5 + lfsr[10:0] at entry.
REQ-035 Start press, react press 3 ms after go_led rises -> state DONE, hex_instructions=100, reaction_ms=3.
REQ-036 Start press, react press during WAIT -> hex_instructions=010, go_led never rises; next start press -> WAIT, reaction_ms unchanged.
REQ-037 GO with no react -> after 20 ms, reaction_ms=20, hex_instructions=100; react held high from before GO -> no capture.
REQ-038 rst asserted mid-GO -> next cycle hex_instructions=001, go_led=0, reaction_ms=0.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game.
// Holds the FSM state enum, the HEX display command codes, the LFSR seed
// and small helpers used by the game FSM.
package reaction_pkg;

    localparam int unsigned LFSR_W = 16;
    localparam int unsigned MS_W   = 14;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned HEX_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_GO   = 3'd2,
        ST_SOON = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [HEX_W-1:0] HEX_OFF  = 3'b000;
    localparam logic [HEX_W-1:0] HEX_PLAY = 3'b001;
    localparam logic [HEX_W-1:0] HEX_SOON = 3'b010;
    localparam logic [HEX_W-1:0] HEX_TIME = 3'b100;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

    // Fibonacci LFSR step, taps 16,14,13,11 (bits 15,13,12,10)
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Display command shown while in a given state
    function automatic logic [HEX_W-1:0] hex_for_state(input state_t s);
        logic [HEX_W-1:0] h;
        h = HEX_OFF;
        case (s)
            ST_IDLE: h = HEX_PLAY;
            ST_SOON: h = HEX_SOON;
            ST_DONE: h = HEX_TIME;
            default: h = HEX_OFF;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..MS_TICKS-1 and flags the last count.
// Ports: clk, rst (sync, active-high), clear (restart count at 0),
//        tick (high for the one cycle the count sits at MS_TICKS-1).
// After a clear the first tick is consumed MS_TICKS edges later.
module ms_tick_gen #(
    parameter int unsigned MS_TICKS = 50_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned PW = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
    localparam logic [PW-1:0] LAST = PW'(MS_TICKS - 1);

    logic [PW-1:0] count;

    // Wrapping prescaler counter
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + PW'(1);
        end
    end

    // Decoded straight from the counter register
    assign tick = (count == LAST);

endmodule

// File: rtl/reaction_game_fsm.sv
// Reaction-time game controller.
// Waits a pseudo-random delay after a start press, lights go_led, and
// measures the time to the react press in milliseconds.
// Ports: clk, rst (sync, active-high), start, react (player buttons, levels)
//        hex_instructions (display command), go_led, reaction_ms (last
//        latched time), busy (high in WAIT and GO). All outputs registered.
module reaction_game_fsm
    import reaction_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned MIN_WAIT_MS = 1000,
    parameter int unsigned MAX_MS      = 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             react,
    output logic [HEX_W-1:0] hex_instructions,
    output logic             go_led,
    output logic [MS_W-1:0]  reaction_ms,
    output logic             busy
);

    localparam int unsigned MS_TICKS = CLK_HZ / 1000;

    state_t              state;
    state_t              state_next;
    logic                start_q;
    logic                react_q;
    logic                start_armed;
    logic                start_press_c;
    logic                react_press_c;
    logic [LFSR_W-1:0]   lfsr;
    logic [CNT_W-1:0]    ms_cnt;
    logic [CNT_W-1:0]    ms_cnt_next;
    logic [CNT_W-1:0]    wait_ms;
    logic [CNT_W-1:0]    wait_ms_next;
    logic [MS_W-1:0]     reaction_next;
    logic                clear_c;
    logic                tick;

    ms_tick_gen #(
        .MS_TICKS (MS_TICKS)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_c),
        .tick  (tick)
    );

    // Input edge detection; start_armed blocks a level held through reset
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q     <= 1'b0;
            react_q     <= 1'b0;
            start_armed <= ~start;
        end else begin
            start_q     <= start;
            react_q     <= react;
            start_armed <= start_armed | ~start;
        end
    end

    assign start_press_c = start & ~start_q & start_armed;
    assign react_press_c = react & ~react_q;

    // Free-running random source
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_next    = state;
        ms_cnt_next   = ms_cnt;
        wait_ms_next  = wait_ms;
        reaction_next = reaction_ms;
        case (state)
            ST_IDLE, ST_SOON, ST_DONE: begin
                if (start_press_c) begin
                    state_next   = ST_WAIT;
                    ms_cnt_next  = '0;
                    wait_ms_next = CNT_W'(MIN_WAIT_MS) + CNT_W'(lfsr[10:0]);
                end
            end
            ST_WAIT: begin
                // react wins even on the tick that would end the wait
                if (react_press_c) begin
                    state_next = ST_SOON;
                end else if (tick) begin
                    if (ms_cnt + CNT_W'(1) >= wait_ms) begin
                        state_next  = ST_GO;
                        ms_cnt_next = '0;
                    end else begin
                        ms_cnt_next = ms_cnt + CNT_W'(1);
                    end
                end
            end
            ST_GO: begin
                if (react_press_c) begin
                    reaction_next = MS_W'(ms_cnt);
                    state_next    = ST_DONE;
                end else if (tick) begin
                    if (ms_cnt + CNT_W'(1) >= CNT_W'(MAX_MS)) begin
                        reaction_next = MS_W'(MAX_MS);
                        state_next    = ST_DONE;
                    end else begin
                        ms_cnt_next = ms_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Restart the prescaler whenever a timed state is entered
    always_comb begin
        clear_c = 1'b0;
        if ((state_next != state) &&
            ((state_next == ST_WAIT) || (state_next == ST_GO))) begin
            clear_c = 1'b1;
        end
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            hex_instructions <= HEX_PLAY;
            go_led           <= 1'b0;
            busy             <= 1'b0;
            reaction_ms      <= '0;
            ms_cnt           <= '0;
            wait_ms          <= '0;
        end else begin
            state            <= state_next;
            hex_instructions <= hex_for_state(state_next);
            go_led           <= (state_next == ST_GO);
            busy             <= (state_next == ST_WAIT) || (state_next == ST_GO);
            reaction_ms      <= reaction_next;
            ms_cnt           <= ms_cnt_next;
            wait_ms          <= wait_ms_next;
        end
    end

endmodule

// File: tb/tb_reaction_game_fsm.sv
// Self-checking bench for reaction_game_fsm with a 4-cycle millisecond.
// Expected delays and reaction times come from game-level rules: the wait
// is (MIN_W + random) whole milliseconds, and a react press reports the
// number of whole milliseconds completed before the press edge.
module tb_reaction_game_fsm;

    localparam int unsigned CLK_HZ   = 4000;
    localparam int unsigned MS       = CLK_HZ / 1000;
    localparam int unsigned MIN_W    = 5;
    localparam int unsigned MAXMS    = 20;
    localparam int unsigned GO_LIMIT = MS * (MIN_W + 2047) + 16;

    logic        clk;
    logic        rst;
    logic        start;
    logic        react;
    logic [2:0]  hex_instructions;
    logic        go_led;
    logic [13:0] reaction_ms;
    logic        busy;

    int unsigned n_tests;
    int unsigned n_fail;
    int unsigned m_reaction;
    logic [15:0] m_lfsr;

    reaction_game_fsm #(
        .CLK_HZ      (CLK_HZ),
        .MIN_WAIT_MS (MIN_W),
        .MAX_MS      (MAXMS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .react            (react),
        .hex_instructions (hex_instructions),
        .go_led           (go_led),
        .reaction_ms      (reaction_ms),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference random source: parity of the tapped bits shifted in at the bottom
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Press start for one cycle; returns the delay the game should pick
    task automatic press_start(output int unsigned w);
        start = 1'b1;
        w = MIN_W + 32'(m_lfsr[10:0]);
        step();
        start = 1'b0;
    endtask

    task automatic run_to_go(output int unsigned n);
        n = 0;
        while (go_led !== 1'b1 && n < GO_LIMIT) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; react = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        n_tests++;
        if (hex_instructions !== 3'b001 || go_led !== 1'b0 || busy !== 1'b0 || reaction_ms !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_state: hex=%b go=%b busy=%b ms=%0d expected hex=001 go=0 busy=0 ms=0",
                     hex_instructions, go_led, busy, reaction_ms);
        end
        repeat (10) step();
        n_tests++;
        if (hex_instructions !== 3'b001 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL held_start: hex=%b busy=%b expected hex=001 busy=0", hex_instructions, busy);
        end
        start = 1'b0;
        react = 1'b1;
        step();
        react = 1'b0;
        repeat (9) step();
        n_tests++;
        if (hex_instructions !== 3'b001 || go_led !== 1'b0 || reaction_ms !== 14'd0) begin
            n_fail++;
            $display("FAIL idle: hex=%b go=%b ms=%0d expected hex=001 go=0 ms=0",
                     hex_instructions, go_led, reaction_ms);
        end
    endtask

    // Called right after go_led rises; presses react on the d-th edge
    task automatic test_react_time(input int unsigned d);
        int unsigned expect_ms;
        repeat (d - 1) step();
        n_tests++;
        if (go_led !== 1'b1) begin
            n_fail++;
            $display("FAIL go_hold d=%0d: go=%b expected 1", d, go_led);
        end
        react = 1'b1;
        step();
        react = 1'b0;
        expect_ms = (d - 1) / MS;
        m_reaction = expect_ms;
        n_tests++;
        if (hex_instructions !== 3'b100 || go_led !== 1'b0 || busy !== 1'b0 ||
            reaction_ms !== 14'(expect_ms)) begin
            n_fail++;
            $display("FAIL react d=%0d: hex=%b go=%b busy=%b ms=%0d expected hex=100 go=0 busy=0 ms=%0d",
                     d, hex_instructions, go_led, busy, reaction_ms, expect_ms);
        end
    endtask

    task automatic test_wait_to_go();
        int unsigned w;
        int unsigned n;
        press_start(w);
        n_tests++;
        if (hex_instructions !== 3'b000 || busy !== 1'b1 || go_led !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_entry: hex=%b busy=%b go=%b expected hex=000 busy=1 go=0",
                     hex_instructions, busy, go_led);
        end
        run_to_go(n);
        n_tests++;
        if (n != MS * w) begin
            n_fail++;
            $display("FAIL wait_len: cycles=%0d expected %0d (wait_ms=%0d)", n, MS * w, w);
        end
        n_tests++;
        if (hex_instructions !== 3'b000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL go_state: hex=%b busy=%b expected hex=000 busy=1", hex_instructions, busy);
        end
        test_react_time(13);
    endtask

    task automatic test_back_to_back();
        int unsigned w;
        int unsigned n;
        for (int i = 0; i < 2; i++) begin
            press_start(w);
            run_to_go(n);
            n_tests++;
            if (n != MS * w) begin
                n_fail++;
                $display("FAIL b2b_wait_len[%0d]: cycles=%0d expected %0d", i, n, MS * w);
            end
            if (i == 0) test_react_time(MS * MAXMS);
            else        test_react_time($urandom_range(1, MS * MAXMS - 1));
        end
    endtask

    task automatic test_too_soon();
        int unsigned w;
        int unsigned d;
        logic        saw_go;
        press_start(w);
        d = $urandom_range(1, MS * MIN_W - 1);
        repeat (d - 1) step();
        react = 1'b1;
        step();
        react = 1'b0;
        n_tests++;
        if (hex_instructions !== 3'b010 || go_led !== 1'b0 || busy !== 1'b0 ||
            reaction_ms !== 14'(m_reaction)) begin
            n_fail++;
            $display("FAIL soon: hex=%b go=%b busy=%b ms=%0d expected hex=010 go=0 busy=0 ms=%0d",
                     hex_instructions, go_led, busy, reaction_ms, m_reaction);
        end
        saw_go = 1'b0;
        repeat (60) begin
            step();
            if (go_led !== 1'b0) saw_go = 1'b1;
        end
        n_tests++;
        if (saw_go !== 1'b0) begin
            n_fail++;
            $display("FAIL soon_no_go: go_led seen=%b expected 0", saw_go);
        end
        press_start(w);
        n_tests++;
        if (hex_instructions !== 3'b000 || busy !== 1'b1 || reaction_ms !== 14'(m_reaction)) begin
            n_fail++;
            $display("FAIL restart_from_soon: hex=%b busy=%b ms=%0d expected hex=000 busy=1 ms=%0d",
                     hex_instructions, busy, reaction_ms, m_reaction);
        end
        // react lands on the same edge as the last wait millisecond
        repeat (MS * w - 1) step();
        n_tests++;
        if (go_led !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_final: go=%b busy=%b expected go=0 busy=1", go_led, busy);
        end
        react = 1'b1;
        step();
        react = 1'b0;
        n_tests++;
        if (hex_instructions !== 3'b010 || go_led !== 1'b0) begin
            n_fail++;
            $display("FAIL final_tick_react: hex=%b go=%b expected hex=010 go=0", hex_instructions, go_led);
        end
    endtask

    task automatic test_timeout();
        int unsigned w;
        int unsigned n;
        int unsigned k;
        react = 1'b1;
        step();
        n_tests++;
        if (hex_instructions !== 3'b010) begin
            n_fail++;
            $display("FAIL react_in_soon: hex=%b expected 010", hex_instructions);
        end
        press_start(w);
        run_to_go(n);
        n_tests++;
        if (n != MS * w) begin
            n_fail++;
            $display("FAIL wait_react_held: cycles=%0d expected %0d", n, MS * w);
        end
        k = 0;
        while (hex_instructions !== 3'b100 && k < MS * MAXMS + 10) begin
            step();
            k++;
        end
        m_reaction = MAXMS;
        n_tests++;
        if (k != MS * MAXMS || reaction_ms !== 14'(MAXMS) || go_led !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout: cycles=%0d ms=%0d go=%b expected cycles=%0d ms=%0d go=0",
                     k, reaction_ms, go_led, MS * MAXMS, MAXMS);
        end
        react = 1'b0;
        step();
        react = 1'b1;
        step();
        react = 1'b0;
        n_tests++;
        if (hex_instructions !== 3'b100 || reaction_ms !== 14'(m_reaction)) begin
            n_fail++;
            $display("FAIL react_in_done: hex=%b ms=%0d expected hex=100 ms=%0d",
                     hex_instructions, reaction_ms, m_reaction);
        end
        step();
    endtask

    task automatic test_ignored_inputs();
        int unsigned w;
        int unsigned d;
        int unsigned n;
        start = 1'b1;
        react = 1'b1;
        w = MIN_W + 32'(m_lfsr[10:0]);
        step();
        start = 1'b0;
        react = 1'b0;
        n_tests++;
        if (hex_instructions !== 3'b000 || busy !== 1'b1 || reaction_ms !== 14'(m_reaction)) begin
            n_fail++;
            $display("FAIL simul_in_done: hex=%b busy=%b ms=%0d expected hex=000 busy=1 ms=%0d",
                     hex_instructions, busy, reaction_ms, m_reaction);
        end
        d = $urandom_range(1, MS * w - 1);
        repeat (d - 1) step();
        start = 1'b1;
        step();
        start = 1'b0;
        run_to_go(n);
        n_tests++;
        if (d + n != MS * w) begin
            n_fail++;
            $display("FAIL start_in_wait: go after %0d cycles expected %0d", d + n, MS * w);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_tests++;
        if (go_led !== 1'b1 || hex_instructions !== 3'b000) begin
            n_fail++;
            $display("FAIL start_in_go: go=%b hex=%b expected go=1 hex=000", go_led, hex_instructions);
        end
    endtask

    task automatic test_reset_mid_go();
        int unsigned w;
        int unsigned n;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_reaction = 0;
        n_tests++;
        if (hex_instructions !== 3'b001 || go_led !== 1'b0 || busy !== 1'b0 || reaction_ms !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_mid_go: hex=%b go=%b busy=%b ms=%0d expected hex=001 go=0 busy=0 ms=0",
                     hex_instructions, go_led, busy, reaction_ms);
        end
        step();
        press_start(w);
        n_tests++;
        if (hex_instructions !== 3'b000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_after_reset: hex=%b busy=%b expected hex=000 busy=1", hex_instructions, busy);
        end
        run_to_go(n);
        n_tests++;
        if (n != MS * w) begin
            n_fail++;
            $display("FAIL wait_after_reset: cycles=%0d expected %0d", n, MS * w);
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        m_reaction = 0;
        rst        = 1'b1;
        start      = 1'b0;
        react      = 1'b0;
        test_reset();
        test_wait_to_go();
        test_back_to_back();
        test_too_soon();
        test_timeout();
        test_ignored_inputs();
        test_reset_mid_go();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
